obuffer: RTL and testbench

- Router output-port buffer: the transmit end of the valid/ready flit link whose receive end is ibuffer.
- Accepts flits from the crossbar on the left side and queues them in a DEPTH-entry FIFO.
- Drives them onto the link toward the downstream router's ibuffer (rvalid/rdata to its lvalid/ldata, rrdy from its lrdy).
- Tracks packet framing so the switch allocator can hold a grant until the tail flit has entered.

---
 rtl/obuffer.sv | 125 ++++++++++++
 tb/tb_obuffer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obuffer.sv
// Router output-port buffer: DEPTH-entry flit FIFO between the crossbar and
// the outgoing valid/ready link, with packet-framing lock for the allocator.
// Optional macro OBUFFER_BYPASS_EN: zero-latency pass-through when the FIFO
// is empty and downstream is ready.
module obuffer #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] ldata,
    input  logic          ltail,
    input  logic          lvalid,
    output logic          lrdy,
    output logic [DW-1:0] rdata,
    output logic          rtail,
    output logic          rvalid,
    input  logic          rrdy,
    output logic          lock,
    output logic [AW:0]   count
);

    localparam int unsigned EW = DW + 1;
    localparam int unsigned CW = AW + 1;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_n;
    logic [AW-1:0] rd_ptr_n;
    logic [CW-1:0] cnt_n;
    logic          lrdy_q;
    logic          rvalid_q;
    logic          rtail_q;
    logic [DW-1:0] rdata_q;
    logic          rvalid_n;
    logic          rtail_n;
    logic [DW-1:0] rdata_n;
    logic          lock_n;
    logic          acc;
    logic          push;
    logic          pop;
    logic          byp;
    logic [EW-1:0] head_n;

    // Handshakes, next pointers/count, and the flit that will sit at the head next cycle
    always_comb begin
        byp      = 1'b0;
`ifdef OBUFFER_BYPASS_EN
        byp      = lrdy_q & (count == CW'(0)) & rrdy;
`endif
        acc      = lvalid & lrdy_q;
        push     = acc & ~byp;
        pop      = rvalid_q & rrdy;

        wr_ptr_n = push ? wr_ptr + AW'(1) : wr_ptr;
        rd_ptr_n = pop  ? rd_ptr + AW'(1) : rd_ptr;

        cnt_n    = count;
        case ({push, pop})
            2'b10:   cnt_n = count + CW'(1);
            2'b01:   cnt_n = count - CW'(1);
            default: cnt_n = count;
        endcase

        // A flit written this cycle into the slot that becomes the head must be forwarded
        head_n   = mem[rd_ptr_n];
        if (push && (wr_ptr == rd_ptr_n)) begin
            head_n = {ltail, ldata};
        end

        rvalid_n = (cnt_n != CW'(0));
        rdata_n  = rvalid_n ? head_n[DW-1:0] : '0;
        rtail_n  = rvalid_n & head_n[DW];

        lock_n   = lock;
        if (acc) begin
            lock_n = ~ltail;
        end
    end

    // Control state and registered link outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            lock     <= 1'b0;
            lrdy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rtail_q  <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            count    <= cnt_n;
            lock     <= lock_n;
            lrdy_q   <= (cnt_n != CW'(DEPTH));
            rvalid_q <= rvalid_n;
            rdata_q  <= rdata_n;
            rtail_q  <= rtail_n;
        end
    end

    // Flit storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ltail, ldata};
        end
    end

    assign lrdy = lrdy_q;

`ifdef OBUFFER_BYPASS_EN
    assign rvalid = byp ? lvalid : rvalid_q;
    assign rdata  = byp ? ldata  : rdata_q;
    assign rtail  = byp ? ltail  : rtail_q;
`else
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rtail  = rtail_q;
`endif

endmodule

// File: tb/tb_obuffer.sv
// Self-checking bench for obuffer against a queue-based reference model.
module tb_obuffer;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned VW    = 3 + DW + AW + 1 + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] ldata;
    logic          ltail;
    logic          lvalid;
    logic          lrdy;
    logic [DW-1:0] rdata;
    logic          rtail;
    logic          rvalid;
    logic          rrdy;
    logic          lock;
    logic [AW:0]   count;

    obuffer #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ldata(ldata), .ltail(ltail), .lvalid(lvalid), .lrdy(lrdy),
        .rdata(rdata), .rtail(rtail), .rvalid(rvalid), .rrdy(rrdy),
        .lock(lock), .count(count)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model: packet queue, lock flag, and "ready after reset" flag
    logic [DW:0] mq[$];
    bit          m_lock;
    bit          m_live;

    logic [VW-1:0] obs;
    assign obs = {lrdy, rvalid, rtail, rdata, count, lock};

    function automatic logic [VW-1:0] expv();
        logic          e_rvalid;
        logic          e_rtail;
        logic [DW-1:0] e_rdata;
        logic [DW:0]   head;
        e_rvalid = (mq.size() != 0);
        head     = e_rvalid ? mq[0] : '0;
        e_rdata  = head[DW-1:0];
        e_rtail  = head[DW];
`ifdef OBUFFER_BYPASS_EN
        if (m_live && mq.size() == 0 && rrdy) begin
            e_rvalid = lvalid;
            e_rdata  = ldata;
            e_rtail  = ltail;
        end
`endif
        return {(m_live && mq.size() != DEPTH), e_rvalid, e_rtail, e_rdata,
                (AW+1)'(mq.size()), m_lock};
    endfunction

    function automatic bit model_lrdy();
        return m_live && (mq.size() < DEPTH);
    endfunction

    // Advance one clock and apply the spec's rules to the model
    task automatic tick();
        bit acc;
        bit byp;
        bit pop;
        @(posedge clk);
        if (rst_n) begin
            acc = lvalid && model_lrdy();
            byp = 1'b0;
`ifdef OBUFFER_BYPASS_EN
            byp = m_live && (mq.size() == 0) && rrdy;
`endif
            pop = (mq.size() != 0) && rrdy;
            if (pop) void'(mq.pop_front());
            if (acc && !byp) mq.push_back({ltail, ldata});
            if (acc) m_lock = !ltail;
            m_live = 1'b1;
        end
        #1;
    endtask

    task automatic assert_reset();
        rst_n  = 1'b0;
        mq.delete();
        m_lock = 1'b0;
        m_live = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [VW-1:0] e;
        lvalid = 1'b0; ldata = '0; ltail = 1'b0; rrdy = 1'b0;
        assert_reset();
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_hold got=%h exp=%h", obs, {VW{1'b0}});
        end
        tick(); tick();
        vectors++;
        if (lrdy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_lrdy got=%b exp=0", lrdy);
        end
        #2 rst_n = 1'b1;
        tick();
        e = expv();
        vectors++;
        if (obs !== e || obs !== {1'b1, {(VW-1){1'b0}}}) begin
            miscompares++;
            $display("FAIL reset_release got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_stream();
        logic [VW-1:0] e;
        rrdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ldata = 8'h55 + 8'(i); ltail = (i == 3); lvalid = 1'b1;
            tick();
            e = expv();
            vectors++;
            if (obs !== e || rdata !== 8'h55 + 8'(i) || rvalid !== 1'b1 ||
                lock !== (i != 3) || count > 3'd1) begin
                miscompares++;
                $display("FAIL stream[%0d] got=%h exp=%h", i, obs, e);
            end
        end
        lvalid = 1'b0;
        tick();
        e = expv();
        vectors++;
        if (obs !== e || count !== 3'd0 || lock !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_end got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_full();
        logic [VW-1:0] e;
        logic [DW-1:0] order [4];
        order[0] = 8'h5A; order[1] = 8'h5B; order[2] = 8'h5C; order[3] = 8'h5D;
        rrdy = 1'b0; ltail = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ldata = 8'h59 + 8'(i); lvalid = 1'b1;
            tick();
            e = expv();
            vectors++;
            if (obs !== e || count !== 3'(i + 1) || rdata !== 8'h59 || rvalid !== 1'b1) begin
                miscompares++;
                $display("FAIL fill[%0d] got=%h exp=%h", i, obs, e);
            end
        end
        ldata = 8'h5D;
        for (int i = 0; i < 2; i++) begin
            tick();
            e = expv();
            vectors++;
            if (obs !== e || lrdy !== 1'b0 || count !== 3'd4 || rdata !== 8'h59) begin
                miscompares++;
                $display("FAIL full_hold[%0d] got=%h exp=%h", i, obs, e);
            end
        end
        rrdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) lvalid = 1'b0;
            tick();
            e = expv();
            vectors++;
            if (obs !== e || rdata !== order[i] || (i < 2 && count !== 3'd3)) begin
                miscompares++;
                $display("FAIL full_drain[%0d] got=%h exp=%h", i, obs, e);
            end
        end
        tick();
        e = expv();
        vectors++;
        if (obs !== e || count !== 3'd0) begin
            miscompares++;
            $display("FAIL full_empty got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_wrap();
        logic [VW-1:0] e;
        rrdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ldata = 8'($urandom); ltail = (i == 3); lvalid = 1'b1;
            tick();
            e = expv();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL wrap_fill[%0d] got=%h exp=%h", i, obs, e);
            end
        end
        lvalid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            rrdy = (i % 2 == 0);
            tick();
            e = expv();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL wrap_drain[%0d] got=%h exp=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] e;
        rrdy = 1'b0; ltail = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ldata = 8'h30 + 8'(i); lvalid = 1'b1;
            tick();
        end
        lvalid = 1'b0;
        e = expv();
        vectors++;
        if (obs !== e || count !== 3'd3 || lock !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_queued got=%h exp=%h", obs, e);
        end
        #2;
        assert_reset();
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL mid_reset got=%h exp=%h", obs, {VW{1'b0}});
        end
        tick();
        #2 rst_n = 1'b1;
        tick();
        ldata = 8'hA0; ltail = 1'b1; lvalid = 1'b1;
        tick();
        lvalid = 1'b0;
        e = expv();
        vectors++;
        if (obs !== e || rtail !== 1'b1 || rdata !== 8'hA0 || lock !== 1'b0) begin
            miscompares++;
            $display("FAIL single_flit got=%h exp=%h", obs, e);
        end
        rrdy = 1'b1;
        tick();
        e = expv();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL single_drain got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] e;
        bit taken;
        lvalid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            taken = lvalid && model_lrdy();
            if (!lvalid || taken) begin
                lvalid = ($urandom_range(0, 2) != 0);
                ldata  = 8'($urandom);
                ltail  = ($urandom_range(0, 3) == 0);
            end
            rrdy = ($urandom_range(0, 2) != 0);
            tick();
            e = expv();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL random[%0d] got=%h exp=%h", i, obs, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; lvalid = 1'b0; ldata = '0; ltail = 1'b0; rrdy = 1'b0;
        m_lock = 1'b0; m_live = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_full();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
